// File: rtl/mpu_common.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mpu_common: shared TileLink D-channel beat, completion entry, D opcodes,   |
// | and the completion-to-D-beat formatter.                        rev 1.0     |
// +----------------------------------------------------------------------------+
package mpu_common;

    localparam int SRC_W     = 4;
    localparam int ERR_MAX_W = 8;

    localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;
    localparam logic [2:0] TL_D_DENIED          = 3'd7;

    typedef struct packed {
        logic [2:0]       opcode;
        logic [31:0]      address;
        logic [31:0]      data;
        logic [SRC_W-1:0] source;
        logic             valid;
        logic             ready;
    } tl_d_channel;

    typedef struct packed {
        logic [SRC_W-1:0]     core_id;
        logic [2:0]           opcode;
        logic [31:0]          addr;
        logic [31:0]          rdata;
        logic [ERR_MAX_W-1:0] err;
    } resp_entry_t;

    typedef enum logic [0:0] {
        DISP_IDLE    = 1'b0,
        DISP_PRESENT = 1'b1
    } disp_state_e;

    // Errors take priority over the write/read distinction.
    function automatic tl_d_channel format_beat(input resp_entry_t e);
        tl_d_channel b;
        b         = '0;
        b.address = e.addr;
        b.source  = e.core_id;
        b.valid   = 1'b1;
        b.ready   = 1'b1;
        if (e.err != '0) begin
            b.opcode = TL_D_DENIED;
            b.data   = {{(32-ERR_MAX_W){1'b0}}, e.err};
        end else if (e.opcode[1]) begin
            b.opcode = TL_D_ACCESS_ACK;
            b.data   = '0;
        end else begin
            b.opcode = TL_D_ACCESS_ACK_DATA;
            b.data   = e.rdata;
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/resp_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | resp_fifo: DEPTH-entry completion FIFO exposing head and head+1 so the     |
// | dispatcher can reload back-to-back.                            rev 1.0     |
// +----------------------------------------------------------------------------+
module resp_fifo
    import mpu_common::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  resp_entry_t            wdata_i,
    output resp_entry_t            head_o,
    output resp_entry_t            next_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    resp_entry_t      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             w_do_push;
    logic             w_do_pop;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;
    assign head_o    = mem_q[rd_ptr_q];
    assign next_o    = mem_q[rd_ptr_q + PTR_W'(1)];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule
`default_nettype wire

// File: rtl/mpu_d_resp_router.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mpu_d_resp_router: queues MPU completions and presents them as D beats on  |
// | the owning core's port. Optional stall timeout: D_RESP_TIMEOUT_EN. rev 1.0 |
// +----------------------------------------------------------------------------+
module mpu_d_resp_router
    import mpu_common::*;
#(
    parameter int NUM_CORES   = 4,
    parameter int DEPTH       = 4,
    parameter int ERR_W       = 3
`ifdef D_RESP_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 64
`endif
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          mpu_rdy,
    input  logic [3:0]                    mpu_core_id,
    input  logic [2:0]                    mpu_opcode,
    input  logic [31:0]                   mpu_addr,
    input  logic [31:0]                   mpu_rdata,
    input  logic [ERR_W-1:0]              mpu_err,
    input  logic [NUM_CORES-1:0]          d_ready,
    output tl_d_channel [NUM_CORES-1:0]   c_resp,
    output logic                          cap_rdy,
    output logic                          overflow,
    output logic                          bad_src
`ifdef D_RESP_TIMEOUT_EN
    ,
    output logic                          timeout_drop
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    disp_state_e      state_q, state_d;
    tl_d_channel      beat_q, beat_d;
    logic             overflow_q;
    logic             bad_src_q;

    resp_entry_t      w_wentry;
    resp_entry_t      w_head;
    resp_entry_t      w_next;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic             w_id_ok;
    logic             w_push;
    logic             w_sel_ready;
    logic             w_to_expire;
    logic             w_retire;
    logic             w_load;

    assign w_id_ok  = (32'(mpu_core_id) < NUM_CORES);
    assign w_push   = mpu_rdy && w_id_ok && !w_full;
    assign w_wentry = '{core_id: mpu_core_id, opcode: mpu_opcode, addr: mpu_addr,
                        rdata: mpu_rdata, err: ERR_MAX_W'(mpu_err)};
    assign cap_rdy  = !w_full;
    assign overflow = overflow_q;
    assign bad_src  = bad_src_q;

    resp_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_push),
        .pop_i   (w_retire),
        .wdata_i (w_wentry),
        .head_o  (w_head),
        .next_o  (w_next),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    // Only the owning port sees the beat; its d_ready is the only one that counts.
    always_comb begin
        w_sel_ready = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            c_resp[i] = '0;
            if ((state_q == DISP_PRESENT) && (32'(beat_q.source) == i)) begin
                c_resp[i]   = beat_q;
                w_sel_ready = d_ready[i];
            end
        end
    end

    assign w_retire = (state_q == DISP_PRESENT) && (w_sel_ready || w_to_expire);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        w_load  = 1'b0;
        case (state_q)
            DISP_IDLE: begin
                if (!w_empty) begin
                    beat_d  = format_beat(w_head);
                    state_d = DISP_PRESENT;
                    w_load  = 1'b1;
                end
            end
            DISP_PRESENT: begin
                // head+1 is only readable if it was already stored before this edge
                if (w_retire) begin
                    if (w_count > CNT_W'(1)) begin
                        beat_d = format_beat(w_next);
                        w_load = 1'b1;
                    end else begin
                        beat_d  = '0;
                        state_d = DISP_IDLE;
                    end
                end
            end
            default: state_d = DISP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= DISP_IDLE;
            beat_q     <= '0;
            overflow_q <= 1'b0;
            bad_src_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            overflow_q <= overflow_q | (mpu_rdy && w_full);
            bad_src_q  <= mpu_rdy && !w_id_ok;
        end
    end

`ifdef D_RESP_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            to_drop_q;

    assign w_to_expire  = (state_q == DISP_PRESENT) && !w_sel_ready &&
                          (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
    assign timeout_drop = to_drop_q;

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (w_load) begin
            to_cnt_d = '0;
        end else if ((state_q == DISP_PRESENT) && !w_sel_ready) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q  <= '0;
            to_drop_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            to_drop_q <= w_to_expire;
        end
    end
`else
    assign w_to_expire = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mpu_d_resp_router.sv
`default_nettype none
// Scoreboard bench for mpu_d_resp_router: expected beats queued at completion,
// compared whenever a beat is presented.
module tb_mpu_d_resp_router;
    import mpu_common::*;

    localparam int NC    = 4;
    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   mpu_rdy = 1'b0;
    logic [3:0]             mpu_core_id = '0;
    logic [2:0]             mpu_opcode = '0;
    logic [31:0]            mpu_addr = '0;
    logic [31:0]            mpu_rdata = '0;
    logic [2:0]             mpu_err = '0;
    logic [NC-1:0]          d_ready = '0;
    tl_d_channel [NC-1:0]   c_resp;
    logic                   cap_rdy;
    logic                   overflow;
    logic                   bad_src;
`ifdef D_RESP_TIMEOUT_EN
    logic                   timeout_drop;
`endif

    int          n_total = 0;
    int          n_bad   = 0;
    int          cyc     = 0;
    logic        exp_ovf = 1'b0;
    tl_d_channel sb[$];
    logic [NC-1:0] w_v;

    always #5 clk = ~clk;

    mpu_d_resp_router #(
        .NUM_CORES   (NC),
        .DEPTH       (DEPTH),
        .ERR_W       (3)
`ifdef D_RESP_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (8)
`endif
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mpu_rdy      (mpu_rdy),
        .mpu_core_id  (mpu_core_id),
        .mpu_opcode   (mpu_opcode),
        .mpu_addr     (mpu_addr),
        .mpu_rdata    (mpu_rdata),
        .mpu_err      (mpu_err),
        .d_ready      (d_ready),
        .c_resp       (c_resp),
        .cap_rdy      (cap_rdy),
        .overflow     (overflow),
        .bad_src      (bad_src)
`ifdef D_RESP_TIMEOUT_EN
        ,
        .timeout_drop (timeout_drop)
`endif
    );

    always_comb begin
        for (int i = 0; i < NC; i++) w_v[i] = c_resp[i].valid;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic tl_d_channel exp_beat(input logic [3:0] id, input logic [2:0] op,
                                             input logic [31:0] a, input logic [31:0] d,
                                             input logic [2:0] e);
        tl_d_channel b;
        b         = '0;
        b.address = a;
        b.source  = id;
        b.valid   = 1'b1;
        b.ready   = 1'b1;
        if (e != 3'd0) begin
            b.opcode = 3'd7;
            b.data   = {29'd0, e};
        end else if (op[1]) begin
            b.opcode = 3'd0;
        end else begin
            b.opcode = 3'd1;
            b.data   = d;
        end
        return b;
    endfunction

    // Called at posedge+1; the model occupancy then equals the DUT's registered count.
    task automatic complete(input logic [3:0] id, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] d, input logic [2:0] e);
        mpu_rdy     = 1'b1;
        mpu_core_id = id;
        mpu_opcode  = op;
        mpu_addr    = a;
        mpu_rdata   = d;
        mpu_err     = e;
        if (sb.size() >= DEPTH) exp_ovf = 1'b1;
        else if (id < NC) sb.push_back(exp_beat(id, op, a, d, e));
        @(posedge clk);
        #1;
        mpu_rdy = 1'b0;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        d_ready = '0;
        sb.delete();
        exp_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain", 128'(sb.size()), 128'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        int nv;
        int sel;
        if (rst_n) begin
`ifdef D_RESP_TIMEOUT_EN
            if (timeout_drop) begin
                if (sb.size() == 0) check("timeout_pop_empty", 128'd1, 128'd0);
                else void'(sb.pop_front());
            end
`endif
            nv  = 0;
            sel = 0;
            for (int i = 0; i < NC; i++) begin
                if (c_resp[i].valid) begin
                    nv++;
                    sel = i;
                end
            end
            if (nv > 1) begin
                check("onehot_valid", 128'(nv), 128'd1);
            end else if (nv == 0) begin
                check("idle_zero", 128'(|c_resp), 128'd0);
            end else if (sb.size() == 0) begin
                check("unexpected_beat", 128'(c_resp[sel]), 128'd0);
            end else begin
                check("beat", 128'(c_resp[sel]), 128'(sb[0]));
                check("port", 128'(sel), 128'(sb[0].source));
                for (int i = 0; i < NC; i++)
                    if (i != sel) check("other_port_zero", 128'(c_resp[i]), 128'd0);
                if (d_ready[sel]) void'(sb.pop_front());
            end
        end
    end

    initial begin
        int n;
        int t0;
        do_reset();

        // Reset state
        @(negedge clk);
        check("rst_cap_rdy", 128'(cap_rdy), 128'd1);
        check("rst_overflow", 128'(overflow), 128'd0);
        check("rst_bad_src", 128'(bad_src), 128'd0);
        check("rst_c_resp", 128'(|c_resp), 128'd0);
        @(posedge clk);
        #1;

        // Read OK on core 2
        d_ready = 4'b0100;
        complete(4'd2, 3'b000, 32'h40, 32'hDEAD_BEEF, 3'd0);
        drain(10);
        repeat (3) @(posedge clk);
        #1;

        // Write ack then error
        d_ready = 4'b1111;
        complete(4'd0, 3'b010, 32'h100, 32'h1234_5678, 3'd0);
        complete(4'd1, 3'b000, 32'h200, 32'h0000_0055, 3'd3);
        drain(10);

        // Backpressure, full, overflow, back-to-back drain
        d_ready = 4'b0000;
        for (int i = 0; i < 4; i++)
            complete(4'(i), 3'(i), 32'h1000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 3'd0);
        @(negedge clk);
        check("full_cap_rdy", 128'(cap_rdy), 128'd0);
        @(posedge clk);
        #1;
        complete(4'd1, 3'b000, 32'h9999, 32'h9999, 3'd0);
        @(negedge clk);
        check("overflow_set", 128'(overflow), 128'(exp_ovf));
        check("full_cap_rdy2", 128'(cap_rdy), 128'd0);
        @(posedge clk);
        #1;
        d_ready = 4'b1111;
        repeat (4) @(negedge clk);
        #1;
        check("b2b_drained", 128'(sb.size()), 128'd0);
        @(posedge clk);
        #1;
        check("cap_rdy_back", 128'(cap_rdy), 128'd1);
        check("overflow_sticky", 128'(overflow), 128'd1);

        // Simultaneous push/pop at count 3, pointer wrap
        do_reset();
        d_ready = 4'b0000;
        for (int i = 0; i < 3; i++)
            complete(4'(i), 3'b000, 32'h2000 + 32'(i), 32'hB000_0000 + 32'(i), 3'd0);
        d_ready = 4'b1111;
        for (int i = 0; i < 10; i++)
            complete(4'(i % 4), 3'((i % 2) * 2), 32'h3000 + 32'(i), 32'hC000_0000 + 32'(i),
                     3'(i % 3 == 2 ? 5 : 0));
        @(negedge clk);
        check("pp_no_overflow", 128'(overflow), 128'd0);
        check("pp_cap_rdy", 128'(cap_rdy), 128'd1);
        @(posedge clk);
        #1;
        drain(10);

        // Bad source
        complete(4'd5, 3'b000, 32'h5555, 32'h5555, 3'd0);
        @(negedge clk);
        check("bad_src_pulse", 128'(bad_src), 128'd1);
        check("bad_src_no_beat", 128'(|w_v), 128'd0);
        @(negedge clk);
        check("bad_src_clear", 128'(bad_src), 128'd0);
        @(posedge clk);
        #1;
        complete(4'd3, 3'b000, 32'h6000, 32'h6666_6666, 3'd0);
        drain(10);

        // Reset mid-PRESENT
        d_ready = 4'b0000;
        complete(4'd3, 3'b000, 32'h7000, 32'h7777_7777, 3'd0);
        @(posedge clk);
        #1;
        check("pre_rst_valid", 128'(w_v), 128'b1000);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("rst_async_clear", 128'(|c_resp), 128'd0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        d_ready = 4'b1111;
        repeat (8) @(posedge clk);
        #1;
        check("post_rst_cap_rdy", 128'(cap_rdy), 128'd1);

`ifdef D_RESP_TIMEOUT_EN
        // Stall timeout
        do_reset();
        d_ready = 4'b0000;
        complete(4'd1, 3'b000, 32'h8000, 32'h8888_0001, 3'd0);
        complete(4'd2, 3'b010, 32'h8004, 32'h8888_0002, 3'd0);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(|w_v) && n < 20);
        check("to_first_valid", 128'(|w_v), 128'd1);
        t0 = cyc;
        n  = 0;
        while (!timeout_drop && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("to_seen", 128'(timeout_drop), 128'd1);
        check("to_latency", 128'(cyc - t0), 128'd8);
        check("to_next_valid", 128'(w_v), 128'b0100);
        @(negedge clk);
        #1;
        check("to_pulse_clear", 128'(timeout_drop), 128'd0);
        d_ready = 4'b1111;
        drain(10);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
